// File: rtl/reg_xfer_pkg.sv
// Shared types and constants for the register-transfer sequencer and its bench.
// Register indices name the relay-computer registers on the shared 8-bit bus.
package reg_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    LOAD,
    LATCH
  } xfer_state_e;

  typedef logic [2:0] reg_idx_t;

  localparam int MAX_REGS = 8;

  localparam reg_idx_t REG_A  = 3'd0;
  localparam reg_idx_t REG_B  = 3'd1;
  localparam reg_idx_t REG_C  = 3'd2;
  localparam reg_idx_t REG_D  = 3'd3;
  localparam reg_idx_t REG_M1 = 3'd4;
  localparam reg_idx_t REG_M2 = 3'd5;
  localparam reg_idx_t REG_X  = 3'd6;
  localparam reg_idx_t REG_Y  = 3'd7;

  function automatic logic [MAX_REGS-1:0] idx_onehot(input reg_idx_t idx);
    return MAX_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_transfer_sequencer_settle_timer.sv
// Phase down-counter: loaded with a cycle count, reports a registered expired
// flag that is high whenever the count has reached zero.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      expired <= 1'b1;
    end else if (load) begin
      count_q <= value;
      expired <= (value == '0);
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
      expired <= (count_q == W'(1));
    end else begin
      expired <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Sequences one register-to-register move or immediate load on the shared bus:
// select source, open destination, latch destination, release bus.
module reg_transfer_sequencer
  import reg_xfer_pkg::*;
#(
  parameter int NUM_REGS      = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          src,
  input  logic [2:0]          dst,
  input  logic                imm_en,
  input  logic [7:0]          imm,
  output logic                ready,
  output logic [NUM_REGS-1:0] sel,
  output logic [NUM_REGS-1:0] load,
  output logic                bus_oe,
  output logic [7:0]          bus_out,
  output logic                done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] PHASE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0] NREGS = 4'(NUM_REGS);

  xfer_state_e state_q, state_d;
  reg_idx_t    src_q, dst_q, src_d, dst_d;
  logic        imm_en_q, imm_en_d;
  logic [7:0]  imm_q, imm_d;
  logic        accept, timer_load, expired;

  logic [MAX_REGS-1:0] src_oh, dst_oh;
  logic [NUM_REGS-1:0] sel_d, load_d;
  logic                busy_d, drive_reg, bus_oe_d, ready_d, done_d;
  logic [7:0]          bus_out_d;

  settle_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .value   (PHASE_LAST),
    .expired (expired)
  );

  assign accept = (state_q == IDLE) && start;

  // Fields are only taken on the accepting edge; starts while busy cannot touch them.
  assign src_d    = accept ? src    : src_q;
  assign dst_d    = accept ? dst    : dst_q;
  assign imm_en_d = accept ? imm_en : imm_en_q;
  assign imm_d    = accept ? imm    : imm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      imm_en_q <= imm_en_d;
      imm_q    <= imm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SELECT;
          timer_load = 1'b1;
        end
      end
      SELECT: begin
        if (expired) begin
          state_d    = LOAD;
          timer_load = 1'b1;
        end
      end
      LOAD: begin
        if (expired) begin
          state_d    = LATCH;
          timer_load = 1'b1;
        end
      end
      LATCH: begin
        if (expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as
  // the state register; the source driver spans all three busy phases while
  // load is confined to the middle phase, so their edges never coincide.
  always_comb begin
    src_oh    = idx_onehot(src_d);
    dst_oh    = idx_onehot(dst_d);
    busy_d    = (state_d != IDLE);
    drive_reg = busy_d && !imm_en_d && (src_d != dst_d) && ({1'b0, src_d} < NREGS);
    sel_d     = drive_reg ? src_oh[NUM_REGS-1:0] : '0;
    load_d    = ((state_d == LOAD) && ({1'b0, dst_d} < NREGS)) ? dst_oh[NUM_REGS-1:0] : '0;
    bus_oe_d  = busy_d && imm_en_d;
    bus_out_d = bus_oe_d ? imm_d : 8'h00;
    ready_d   = (state_d == IDLE);
    done_d    = (state_q == LATCH) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready   <= 1'b1;
      sel     <= '0;
      load    <= '0;
      bus_oe  <= 1'b0;
      bus_out <= 8'h00;
      done    <= 1'b0;
    end else begin
      ready   <= ready_d;
      sel     <= sel_d;
      load    <= load_d;
      bus_oe  <= bus_oe_d;
      bus_out <= bus_out_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Bench for reg_transfer_sequencer: per-cycle phase model, behavioural register
// bank on the bus, and a second instance with six registers for range checks.
module tb_reg_transfer_sequencer;

  localparam int S    = 2;
  localparam int LAST = 3 * S + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] src, dst;
  logic       imm_en;
  logic [7:0] imm;

  logic       ready, bus_oe, done;
  logic [7:0] sel, load, bus_out;
  logic       ready6, bus_oe6, done6;
  logic [5:0] sel6, load6;
  logic [7:0] bus_out6;

  int n_vec;
  int n_err;

  logic [7:0] bank [8];
  logic [7:0] exp_bank [8];
  logic [7:0] bus;
  logic       pre_we;
  logic [2:0] pre_idx;
  logic [7:0] pre_val;

  always #5 clk = ~clk;

  reg_transfer_sequencer #(.NUM_REGS(8), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst),
    .imm_en(imm_en), .imm(imm), .ready(ready), .sel(sel), .load(load),
    .bus_oe(bus_oe), .bus_out(bus_out), .done(done)
  );

  reg_transfer_sequencer #(.NUM_REGS(6), .SETTLE_CYCLES(S)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst),
    .imm_en(imm_en), .imm(imm), .ready(ready6), .sel(sel6), .load(load6),
    .bus_oe(bus_oe6), .bus_out(bus_out6), .done(done6)
  );

  // Behavioural register bank: each register follows the bus while its load is high.
  always_comb begin
    bus = bus_oe ? bus_out : 8'h00;
    for (int i = 0; i < 8; i++) if (sel[i]) bus = bus | bank[i];
  end

  always @(posedge clk) begin
    if (pre_we) bank[pre_idx] <= pre_val;
    else for (int i = 0; i < 8; i++) if (load[i]) bank[i] <= bus;
  end

  // Reference model: expected outputs in cycle c (1 = first cycle after the accepting edge).
  function automatic logic [7:0] m_sel(int c, int n, int s, int d, bit ie);
    if (c <= 3 * S && !ie && s != d && s < n) return 8'(1 << s);
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_load(int c, int n, int d);
    if (c > S && c <= 2 * S && d < n) return 8'(1 << d);
    return 8'h00;
  endfunction

  task automatic preload(input int idx, input logic [7:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 3'(idx); pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
    exp_bank[idx] = val;
  endtask

  task automatic check_transfer(input int s, input int d, input bit ie, input logic [7:0] iv);
    logic [7:0] e_sel, e_load, e_sel6, e_load6, e_out;
    logic [7:0] p_sel, p_load;
    logic       e_oe, e_fin, p_oe;
    p_sel = 8'h00; p_load = 8'h00; p_oe = 1'b0;
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      e_sel   = m_sel(c, 8, s, d, ie);
      e_load  = m_load(c, 8, d);
      e_sel6  = m_sel(c, 6, s, d, ie);
      e_load6 = m_load(c, 6, d);
      e_oe    = (c <= 3 * S) && ie;
      e_out   = e_oe ? iv : 8'h00;
      e_fin   = (c == LAST);
      n_vec += 11;
      if (sel !== e_sel) begin n_err++; $display("FAIL sel c%0d: got %h want %h", c, sel, e_sel); end
      if (load !== e_load) begin n_err++; $display("FAIL load c%0d: got %h want %h", c, load, e_load); end
      if (bus_oe !== e_oe) begin n_err++; $display("FAIL bus_oe c%0d: got %b want %b", c, bus_oe, e_oe); end
      if (bus_out !== e_out) begin n_err++; $display("FAIL bus_out c%0d: got %h want %h", c, bus_out, e_out); end
      if (done !== e_fin) begin n_err++; $display("FAIL done c%0d: got %b want %b", c, done, e_fin); end
      if (ready !== e_fin) begin n_err++; $display("FAIL ready c%0d: got %b want %b", c, ready, e_fin); end
      if (sel6 !== e_sel6[5:0]) begin n_err++; $display("FAIL sel6 c%0d: got %h want %h", c, sel6, e_sel6[5:0]); end
      if (load6 !== e_load6[5:0]) begin n_err++; $display("FAIL load6 c%0d: got %h want %h", c, load6, e_load6[5:0]); end
      if (done6 !== e_fin) begin n_err++; $display("FAIL done6 c%0d: got %b want %b", c, done6, e_fin); end
      if ($countones(sel) > 1 || $countones(load) > 1 || (bus_oe && |sel)) begin
        n_err++; $display("FAIL bus_contention c%0d: sel %h load %h oe %b", c, sel, load, bus_oe);
      end
      if ((load != p_load) && ((sel != p_sel) || (bus_oe != p_oe))) begin
        n_err++; $display("FAIL edge_overlap c%0d: load %h->%h sel %h->%h", c, p_load, load, p_sel, sel);
      end
      p_sel = sel; p_load = load; p_oe = bus_oe;
    end
    if (ie) exp_bank[d] = iv;
    else if (s == d) exp_bank[d] = 8'h00;
    else exp_bank[d] = exp_bank[s];
    n_vec++;
    if (bank[d] !== exp_bank[d]) begin
      n_err++; $display("FAIL bank[%0d]: got %h want %h", d, bank[d], exp_bank[d]);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL ready_timeout: got %b want 1", ready); end
  endtask

  // Drives one request and scrambles the inputs right after acceptance.
  task automatic run_xfer(input int s, input int d, input bit ie, input logic [7:0] iv);
    wait_ready();
    @(negedge clk);
    start = 1'b1; src = 3'(s); dst = 3'(d); imm_en = ie; imm = iv;
    @(posedge clk);
    #1;
    start = 1'b0; src = 3'($urandom); dst = 3'($urandom); imm_en = 1'($urandom); imm = 8'($urandom);
    check_transfer(s, d, ie, iv);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec += 3;
    if ({ready, ready6} !== 2'b11) begin n_err++; $display("FAIL reset_ready: got %b want 11", {ready, ready6}); end
    if ({sel, load, bus_out} !== 24'h0) begin n_err++; $display("FAIL reset_outs: got %h want 0", {sel, load, bus_out}); end
    if ({bus_oe, done, bus_oe6, done6} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0", {bus_oe, done, bus_oe6, done6}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec += 2;
    if (ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", ready); end
    if ({sel, load, bus_oe, done} !== 18'h0) begin n_err++; $display("FAIL post_reset_idle: got %h want 0", {sel, load, bus_oe, done}); end
  endtask

  task automatic test_reg_move();
    preload(1, 8'h3C);
    run_xfer(1, 2, 1'b0, 8'h00);
  endtask

  task automatic test_immediate();
    run_xfer(0, 0, 1'b1, 8'hA5);
    run_xfer(3, 6, 1'b1, 8'($urandom));
  endtask

  task automatic test_clear();
    preload(3, 8'hFF);
    run_xfer(3, 3, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    int s2, d2;
    s2 = $urandom_range(0, 7); d2 = $urandom_range(0, 7);
    wait_ready();
    @(negedge clk);
    start = 1'b1; src = 3'd4; dst = 3'd5; imm_en = 1'b0; imm = 8'h00;
    @(posedge clk);
    #1;
    src = 3'(s2); dst = 3'(d2);
    check_transfer(4, 5, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_transfer(s2, d2, 1'b0, 8'h00);
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    wait_ready();
    @(negedge clk);
    start = 1'b1; src = 3'd6; dst = 3'd7; imm_en = 1'b0; imm = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    fork
      check_transfer(6, 7, 1'b0, 8'h00);
      begin
        repeat (3) @(negedge clk);
        start = 1'b1; src = 3'd0; dst = 3'd1; imm_en = 1'b1; imm = 8'h5A;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
      n_vec++;
      if (ready !== 1'b1 || sel !== 8'h00 || bus_oe !== 1'b0) begin
        n_err++; $display("FAIL ignored_start_idle: ready %b sel %h oe %b want 1 00 0", ready, sel, bus_oe);
      end
    end
    n_vec++;
    if (dones !== 0) begin n_err++; $display("FAIL ignored_start_done: got %0d extra want 0", dones); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] snap;
    wait_ready();
    @(negedge clk);
    start = 1'b1; src = 3'd0; dst = 3'd5; imm_en = 1'b0; imm = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    snap = load;
    n_vec++;
    if (snap !== 8'h20) begin n_err++; $display("FAIL mid_load: got %h want 20", snap); end
    #1 rst_n = 1'b0;
    #1;
    n_vec += 2;
    if ({sel, load, bus_oe, done} !== 18'h0) begin n_err++; $display("FAIL async_drop: got %h want 0", {sel, load, bus_oe, done}); end
    if (ready !== 1'b1) begin n_err++; $display("FAIL async_ready: got %b want 1", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL after_abort: done %b ready %b want 0 1", done, ready); end
    end
    run_xfer(2, 4, 1'b0, 8'h00);
  endtask

  task automatic test_dst_oob();
    run_xfer(2, 7, 1'b0, 8'h00);
    run_xfer(6, 1, 1'b0, 8'h00);
    run_xfer(0, 6, 1'b1, 8'h77);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_xfer($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 8'($urandom));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; imm_en = 1'b0; imm = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    test_reset();
    for (int i = 0; i < 8; i++) preload(i, 8'($urandom));
    test_reg_move();
    test_immediate();
    test_clear();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_dst_oob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
